// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron training sequencer.
package perceptron_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FEED  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // Q16.16 constants
   localparam logic [31:0] Q16_ONE     = 32'h0001_0000;
   localparam logic [31:0] TOL_DEFAULT = 32'h0000_4000;

   localparam int unsigned N_DEFAULT     = 8;
   localparam int unsigned DEPTH_DEFAULT = 16;
   localparam int unsigned ADDR_W        = $clog2(DEPTH_DEFAULT);
   localparam int unsigned CNT_W         = ADDR_W + 1;

   // |a - b| with the difference formed as a 33-bit signed value
   function automatic logic [32:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] d;
      d = {1'b0, a} - {1'b0, b};
      return d[32] ? (33'd0 - d) : d;
   endfunction

endpackage

// File: rtl/perceptron_trainer_if.sv
// Host / perceptron side bus of the training sequencer.
interface perceptron_trainer_if
   import perceptron_pkg::*;
#(
   parameter int unsigned N     = N_DEFAULT,
   parameter int unsigned DEPTH = DEPTH_DEFAULT
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic          start;
   logic          abort;
   logic [31:0]   learning_rate;
   logic [CW-1:0] num_samples;
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [N-2:0]  load_x;
   logic [31:0]   load_y;
   logic [N-2:0]  p_x;
   logic          p_train;
   logic [31:0]   p_learning_rate;
   logic [31:0]   p_expected_y;
   logic [31:0]   p_y;
   logic          busy;
   logic          done;
   logic          converged;
   logic [7:0]    epoch_count;
   logic [CW-1:0] error_count;

   // host and perceptron side
   modport master (
      output start, abort, learning_rate, num_samples,
      output load_en, load_addr, load_x, load_y, p_y,
      input  p_x, p_train, p_learning_rate, p_expected_y,
      input  busy, done, converged, epoch_count, error_count
   );

   // trainer side
   modport slave (
      input  start, abort, learning_rate, num_samples,
      input  load_en, load_addr, load_x, load_y, p_y,
      output p_x, p_train, p_learning_rate, p_expected_y,
      output busy, done, converged, epoch_count, error_count
   );

endinterface

// File: rtl/perceptron_trainer_sample_store.sv
// Labelled sample register file: one synchronous write, one combinational read.
module sample_store #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned W     = 39,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [DEPTH];

   // write port; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/perceptron_trainer.sv
// Training sequencer: streams stored samples into a perceptron, scores the
// delayed outputs against their labels and repeats epochs until clean.
module perceptron_trainer
   import perceptron_pkg::*;
#(
   parameter int unsigned N          = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned LATENCY    = 4,
   parameter int unsigned MAX_EPOCHS = 255,
   parameter logic [31:0] TOL        = TOL_DEFAULT
) (
   input logic           clk,
   input logic           rst,
   perceptron_trainer_if.slave bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned XW = N - 1;
   localparam int unsigned LW = $clog2(LATENCY + 1);

   state_e        state_q, state_d;
   logic [CW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] ns_q, ns_d;
   logic [LW-1:0] drain_q, drain_d;
   logic [31:0]   lr_q, lr_d;
   logic [XW-1:0] px_q, px_d;
   logic          ptrain_q, ptrain_d;
   logic [31:0]   pey_q, pey_d;
   logic          conv_q, conv_d;
   logic [7:0]    epoch_q, epoch_d;
   logic [CW-1:0] err_q, err_d;
   logic          err_clr;
   logic          flush;

   logic [LATENCY-1:0] dl_v_q;
   logic [31:0]        dl_y_q [LATENCY];

   logic          busy;
   logic [CW-1:0] ns_in;
   logic [AW-1:0] rd_addr;
   logic [XW+31:0] rd_data;
   logic [XW-1:0] rd_x;
   logic [31:0]   rd_y;
   logic          score_err;

   assign busy    = (state_q == ST_FEED) || (state_q == ST_DRAIN) || (state_q == ST_CHECK);
   assign ns_in   = (bus.num_samples > CW'(DEPTH)) ? CW'(DEPTH) : bus.num_samples;
   assign rd_addr = (state_q == ST_FEED) ? ptr_q[AW-1:0] : '0;
   assign rd_x    = rd_data[XW+31:32];
   assign rd_y    = rd_data[31:0];

   sample_store #(
      .DEPTH (DEPTH),
      .W     (XW + 32)
   ) u_store (
      .clk     (clk),
      .we_i    (bus.load_en && !busy),
      .waddr_i (bus.load_addr),
      .wdata_i ({bus.load_x, bus.load_y}),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

   assign score_err = dl_v_q[LATENCY-1] &&
                      (abs_diff(bus.p_y, dl_y_q[LATENCY-1]) > {1'b0, TOL});

   // next-state, next outputs and counter updates
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      ns_d     = ns_q;
      drain_d  = drain_q;
      lr_d     = lr_q;
      px_d     = px_q;
      ptrain_d = ptrain_q;
      pey_d    = pey_q;
      conv_d   = conv_q;
      epoch_d  = epoch_q;
      err_clr  = 1'b0;
      flush    = 1'b0;

      // sample 0 is put on the registered outputs at the edge that enters
      // FEED, so the pointer already reads 1 during the first FEED cycle
      unique case (state_q)
         ST_IDLE: begin
            if (!bus.abort && bus.start) begin
               lr_d    = bus.learning_rate;
               epoch_d = '0;
               conv_d  = 1'b0;
               err_clr = 1'b1;
               if (ns_in == '0) begin
                  conv_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  ns_d     = ns_in;
                  px_d     = rd_x;
                  pey_d    = rd_y;
                  ptrain_d = 1'b1;
                  ptr_d    = CW'(1);
                  state_d  = ST_FEED;
               end
            end
         end
         ST_FEED: begin
            if (ptr_q == ns_q) begin
               ptrain_d = 1'b0;
               px_d     = '0;
               pey_d    = '0;
               drain_d  = '0;
               state_d  = ST_DRAIN;
            end else begin
               px_d     = rd_x;
               pey_d    = rd_y;
               ptrain_d = 1'b1;
               ptr_d    = ptr_q + CW'(1);
            end
         end
         ST_DRAIN: begin
            if (drain_q == LW'(LATENCY - 1)) state_d = ST_CHECK;
            else                             drain_d = drain_q + LW'(1);
         end
         ST_CHECK: begin
            epoch_d = epoch_q + 8'd1;
            if (err_q == '0) begin
               conv_d  = 1'b1;
               state_d = ST_DONE;
            end else if (epoch_d == 8'(MAX_EPOCHS)) begin
               state_d = ST_DONE;
            end else begin
               err_clr  = 1'b1;
               px_d     = rd_x;
               pey_d    = rd_y;
               ptrain_d = 1'b1;
               ptr_d    = CW'(1);
               state_d  = ST_FEED;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (bus.abort && busy) begin
         state_d  = ST_IDLE;
         ptrain_d = 1'b0;
         px_d     = '0;
         pey_d    = '0;
         epoch_d  = epoch_q;
         conv_d   = conv_q;
         err_clr  = 1'b0;
         flush    = 1'b1;
      end

      if (err_clr)                      err_d = '0;
      else if (score_err && err_q != '1) err_d = err_q + CW'(1);
      else                              err_d = err_q;
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // datapath, perceptron-facing outputs and status counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q    <= '0;
         ns_q     <= '0;
         drain_q  <= '0;
         lr_q     <= '0;
         px_q     <= '0;
         ptrain_q <= 1'b0;
         pey_q    <= '0;
         conv_q   <= 1'b0;
         epoch_q  <= '0;
         err_q    <= '0;
      end else begin
         ptr_q    <= ptr_d;
         ns_q     <= ns_d;
         drain_q  <= drain_d;
         lr_q     <= lr_d;
         px_q     <= px_d;
         ptrain_q <= ptrain_d;
         pey_q    <= pey_d;
         conv_q   <= conv_d;
         epoch_q  <= epoch_d;
         err_q    <= err_d;
      end
   end

   // label delay line fed from the registered outputs so its tail lines up with p_y
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dl_v_q <= '0;
         for (int unsigned i = 0; i < LATENCY; i++) dl_y_q[i] <= '0;
      end else if (flush) begin
         dl_v_q <= '0;
         for (int unsigned i = 0; i < LATENCY; i++) dl_y_q[i] <= '0;
      end else begin
         dl_v_q[0] <= ptrain_q;
         dl_y_q[0] <= pey_q;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            dl_v_q[i] <= dl_v_q[i-1];
            dl_y_q[i] <= dl_y_q[i-1];
         end
      end
   end

   assign bus.p_x             = px_q;
   assign bus.p_train         = ptrain_q;
   assign bus.p_learning_rate = lr_q;
   assign bus.p_expected_y    = pey_q;
   assign bus.busy            = busy;
   assign bus.done            = (state_q == ST_DONE);
   assign bus.converged       = conv_q;
   assign bus.epoch_count     = epoch_q;
   assign bus.error_count     = err_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer with a delayed-label perceptron stub.
module tb_perceptron_trainer;
   import perceptron_pkg::*;

   localparam int unsigned N     = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned LAT   = 4;
   localparam int unsigned MAXE  = 3;

   logic clk = 1'b0;
   logic rst;

   perceptron_trainer_if #(.N(N), .DEPTH(DEPTH)) bus ();

   perceptron_trainer #(
      .N          (N),
      .DEPTH      (DEPTH),
      .LATENCY    (LAT),
      .MAX_EPOCHS (MAXE),
      .TOL        (TOL_DEFAULT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // perceptron stub: p_y is the presented label LAT cycles later plus an offset
   int          stub_mode;
   logic [31:0] pipe_y [LAT];
   logic [6:0]  pipe_x [LAT];

   function automatic logic [31:0] stub_off(input int mode, input logic [6:0] x);
      case (mode)
         1:       return Q16_ONE;
         2:       return (x == 7'h11) ? TOL_DEFAULT : TOL_DEFAULT + 32'd1;
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) begin
      pipe_y[0] <= bus.p_expected_y;
      pipe_x[0] <= bus.p_x;
      for (int i = 1; i < LAT; i++) begin
         pipe_y[i] <= pipe_y[i-1];
         pipe_x[i] <= pipe_x[i-1];
      end
   end

   assign bus.p_y = pipe_y[LAT-1] + stub_off(stub_mode, pipe_x[LAT-1]);

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_seen = 0;

   localparam logic [31:0] Y0 = 32'h0001_8000;
   localparam logic [31:0] Y1 = 32'h0000_0100;
   localparam logic [31:0] Y2 = 32'h0000_4000;
   localparam logic [31:0] Y3 = 32'h0003_0000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done === 1'b1) done_seen++;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) tick();
   endtask

   task automatic load(input int addr, input logic [6:0] x, input logic [31:0] y);
      bus.load_en   = 1'b1;
      bus.load_addr = 4'(addr);
      bus.load_x    = x;
      bus.load_y    = y;
      tick();
      bus.load_en   = 1'b0;
   endtask

   task automatic go(input int ns);
      bus.num_samples = 5'(ns);
      bus.start       = 1'b1;
      cyc             = 0;
      done_seen       = 0;
      tick();
      bus.start       = 1'b0;
   endtask

   initial begin
      rst                = 1'b1;
      stub_mode          = 0;
      bus.start          = 1'b0;
      bus.abort          = 1'b0;
      bus.learning_rate  = 32'h0000_0800;
      bus.num_samples    = '0;
      bus.load_en        = 1'b0;
      bus.load_addr      = '0;
      bus.load_x         = '0;
      bus.load_y         = '0;
      tick();
      tick();
      chk("rst_p_x",     32'(bus.p_x), 32'h0);
      chk("rst_p_train", 32'(bus.p_train), 32'h0);
      chk("rst_p_ey",    bus.p_expected_y, 32'h0);
      chk("rst_p_lr",    bus.p_learning_rate, 32'h0);
      chk("rst_busy",    32'(bus.busy), 32'h0);
      chk("rst_done",    32'(bus.done), 32'h0);
      chk("rst_conv",    32'(bus.converged), 32'h0);
      chk("rst_epoch",   32'(bus.epoch_count), 32'h0);
      chk("rst_err",     32'(bus.error_count), 32'h0);
      rst = 1'b0;
      tick();

      load(0, 7'h11, Y0);
      load(1, 7'h22, Y1);
      load(2, 7'h33, Y2);
      load(3, 7'h44, Y3);

      // convergence: 4 samples, exact labels
      stub_mode = 0;
      go(4);
      chk("conv_c1_train", 32'(bus.p_train), 32'h1);
      chk("conv_c1_x",     32'(bus.p_x), 32'h11);
      chk("conv_c1_ey",    bus.p_expected_y, Y0);
      chk("conv_c1_lr",    bus.p_learning_rate, 32'h0000_0800);
      chk("conv_c1_busy",  32'(bus.busy), 32'h1);
      tick();
      chk("conv_c2_x",     32'(bus.p_x), 32'h22);
      run_to(4);
      chk("conv_c4_train", 32'(bus.p_train), 32'h1);
      chk("conv_c4_x",     32'(bus.p_x), 32'h44);
      tick();
      chk("conv_c5_train", 32'(bus.p_train), 32'h0);
      chk("conv_c5_x",     32'(bus.p_x), 32'h0);
      chk("conv_c5_busy",  32'(bus.busy), 32'h1);
      run_to(9);
      chk("conv_early_done", 32'(done_seen), 32'h0);
      tick();
      chk("conv_c10_done",  32'(bus.done), 32'h1);
      chk("conv_c10_conv",  32'(bus.converged), 32'h1);
      chk("conv_c10_epoch", 32'(bus.epoch_count), 32'h1);
      chk("conv_c10_err",   32'(bus.error_count), 32'h0);
      chk("conv_c10_busy",  32'(bus.busy), 32'h0);
      tick();
      chk("conv_c11_done",  32'(bus.done), 32'h0);
      chk("conv_c11_conv",  32'(bus.converged), 32'h1);

      // epoch limit: every output off by 1.0; store write while busy is dropped
      stub_mode = 1;
      go(2);
      run_to(2);
      chk("lim_c2_x", 32'(bus.p_x), 32'h22);
      load(0, 7'h55, 32'h0000_1234);
      run_to(7);
      chk("lim_c7_err",  32'(bus.error_count), 32'h2);
      chk("lim_c7_busy", 32'(bus.busy), 32'h1);
      tick();
      chk("lim_c8_x",     32'(bus.p_x), 32'h11);
      chk("lim_c8_ey",    bus.p_expected_y, Y0);
      chk("lim_c8_epoch", 32'(bus.epoch_count), 32'h1);
      chk("lim_c8_err",   32'(bus.error_count), 32'h0);
      run_to(21);
      chk("lim_early_done", 32'(done_seen), 32'h0);
      tick();
      chk("lim_c22_done",  32'(bus.done), 32'h1);
      chk("lim_c22_conv",  32'(bus.converged), 32'h0);
      chk("lim_c22_epoch", 32'(bus.epoch_count), 32'h3);
      chk("lim_c22_err",   32'(bus.error_count), 32'h2);
      tick();

      // tolerance boundary: +TOL passes, +TOL+1 fails
      stub_mode = 2;
      go(2);
      run_to(7);
      chk("tol_c7_err",   32'(bus.error_count), 32'h1);
      chk("tol_c7_epoch", 32'(bus.epoch_count), 32'h0);
      tick();
      chk("tol_c8_train", 32'(bus.p_train), 32'h1);
      chk("tol_c8_epoch", 32'(bus.epoch_count), 32'h1);
      run_to(22);
      chk("tol_c22_done", 32'(bus.done), 32'h1);
      chk("tol_c22_err",  32'(bus.error_count), 32'h1);
      tick();

      // abort in FEED
      stub_mode = 0;
      go(4);
      run_to(3);
      chk("abt_c3_train", 32'(bus.p_train), 32'h1);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("abt_c4_train", 32'(bus.p_train), 32'h0);
      chk("abt_c4_busy",  32'(bus.busy), 32'h0);
      chk("abt_c4_x",     32'(bus.p_x), 32'h0);
      run_to(14);
      chk("abt_no_done", 32'(done_seen), 32'h0);
      go(4);
      chk("abt_re_x",     32'(bus.p_x), 32'h11);
      chk("abt_re_train", 32'(bus.p_train), 32'h1);
      chk("abt_re_epoch", 32'(bus.epoch_count), 32'h0);
      run_to(10);
      chk("abt_re_done", 32'(bus.done), 32'h1);
      chk("abt_re_conv", 32'(bus.converged), 32'h1);
      tick();

      // abort and start together in IDLE
      bus.abort = 1'b1;
      go(4);
      bus.abort = 1'b0;
      chk("as_busy",  32'(bus.busy), 32'h0);
      chk("as_train", 32'(bus.p_train), 32'h0);
      chk("as_epoch", 32'(bus.epoch_count), 32'h1);

      // zero samples
      go(0);
      chk("zero_done",  32'(bus.done), 32'h1);
      chk("zero_conv",  32'(bus.converged), 32'h1);
      chk("zero_epoch", 32'(bus.epoch_count), 32'h0);
      chk("zero_busy",  32'(bus.busy), 32'h0);
      tick();
      chk("zero_done_off", 32'(bus.done), 32'h0);

      // reset asserted in the middle of FEED
      bus.learning_rate = 32'h0000_1000;
      go(4);
      run_to(2);
      #2 rst = 1'b1;
      #1;
      chk("mrst_train", 32'(bus.p_train), 32'h0);
      chk("mrst_x",     32'(bus.p_x), 32'h0);
      chk("mrst_ey",    bus.p_expected_y, 32'h0);
      chk("mrst_lr",    bus.p_learning_rate, 32'h0);
      chk("mrst_busy",  32'(bus.busy), 32'h0);
      #1 rst = 1'b0;
      go(4);
      chk("mrst_re_x",  32'(bus.p_x), 32'h11);
      chk("mrst_re_lr", bus.p_learning_rate, 32'h0000_1000);
      run_to(10);
      chk("mrst_re_done", 32'(bus.done), 32'h1);
      tick();

      // load in the same cycle as start: first run sees old contents
      bus.load_en   = 1'b1;
      bus.load_addr = 4'd0;
      bus.load_x    = 7'h77;
      bus.load_y    = Y3;
      go(1);
      bus.load_en   = 1'b0;
      chk("ld_old_x", 32'(bus.p_x), 32'h11);
      run_to(7);
      chk("ld_old_done", 32'(bus.done), 32'h1);
      tick();
      go(1);
      chk("ld_new_x",  32'(bus.p_x), 32'h77);
      chk("ld_new_ey", bus.p_expected_y, Y3);
      run_to(7);
      chk("ld_new_done", 32'(bus.done), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
